// File: rtl/arp_pkg.sv
// arp_pkg -- shared definitions for the ARP responder.
//   * byte offsets of the request/reply fields within the 42-byte frame
//   * expected request header constants and the fixed reply header
//   * reply-queue entry type {sha, spa, idx} and the TX state encoding
package arp_pkg;

  localparam logic [5:0] ARP_LEN     = 6'd42;  // request parse length and reply length
  localparam logic [5:0] OFF_DST     = 6'd0;   // destination MAC, bytes 0..5
  localparam logic [5:0] OFF_SRC     = 6'd6;   // source MAC, bytes 6..11
  localparam logic [5:0] OFF_HDR     = 6'd12;  // ethertype..OP, bytes 12..21
  localparam logic [5:0] OFF_HDR_END = 6'd21;
  localparam logic [5:0] OFF_SHA     = 6'd22;  // sender MAC, bytes 22..27
  localparam logic [5:0] OFF_SPA     = 6'd28;  // sender IPv4, bytes 28..31
  localparam logic [5:0] OFF_THA     = 6'd32;  // target MAC, bytes 32..37
  localparam logic [5:0] OFF_TPA     = 6'd38;  // target IPv4, bytes 38..41
  localparam logic [5:0] OFF_LAST    = 6'd41;

  localparam int REPLY_BITS = 336;             // 42 bytes

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  // ethertype, HRD, PRO, HLN, PLN, OP
  localparam logic [79:0] REQ_HDR   = 80'h0806_0001_0800_06_04_0001;
  localparam logic [79:0] RSP_HDR   = 80'h0806_0001_0800_06_04_0002;

  localparam int IDX_W    = 3;
  localparam int MAX_IPV4 = 8;

  typedef struct packed {
    logic [47:0]      sha;
    logic [31:0]      spa;
    logic [IDX_W-1:0] idx;
  } arp_entry_t;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_PENDING = 2'd1,
    TX_SEND    = 2'd2
  } tx_state_e;

  // Expected request header byte for frame offsets OFF_HDR..OFF_HDR_END.
  function automatic logic [7:0] req_hdr_byte(input logic [5:0] off);
    logic [3:0] rel;
    rel = 4'(OFF_HDR_END - off);
    return REQ_HDR[{rel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/arp_reply_fifo.sv
// arp_reply_fifo -- first-word-fall-through queue of pending ARP replies.
//   clk_i    clock            arst_i  asynchronous active-high reset (empties queue)
//   push_i   write request    wdata_i entry to write
//   pop_i    read request     rdata_o head entry (valid whenever !empty_o)
//   empty_o / full_o status
// A push while full is accepted when a pop happens on the same edge.
module arp_reply_fifo
  import arp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       push_i,
  input  arp_entry_t wdata_i,
  input  logic       pop_i,
  output arp_entry_t rdata_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full (MSBs differ) from empty.
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  arp_entry_t  mem [DEPTH];
  logic        wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign rdata_o = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/arp_response_multi.sv
// arp_response_multi -- answers ARP requests for up to 8 local IPv4 addresses.
//   CLK, ARESET          clock, asynchronous active-high reset
//   MY_MAC, MY_IPV4      local MAC and addresses (entry k at [32k+31:32k])
//   IPV4_EN              per-address enable
//   DATA_VALID_RX/DATA_RX  receive byte stream
//   DATA_ACK_TX          one-cycle start pulse from the MAC
//   DATA_VALID_TX/DATA_TX  reply pending/in-flight and reply byte
// Optional macro ARP_STATS_EN adds saturating REQ_COUNT / DROP_COUNT outputs.
module arp_response_multi
  import arp_pkg::*;
#(
  parameter int NUM_IPV4    = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  ARESET,
  input  logic [47:0]           MY_MAC,
  input  logic [32*NUM_IPV4-1:0] MY_IPV4,
  input  logic [NUM_IPV4-1:0]   IPV4_EN,
  input  logic                  DATA_VALID_RX,
  input  logic [7:0]            DATA_RX,
  input  logic                  DATA_ACK_TX,
  output logic                  DATA_VALID_TX,
  output logic [7:0]            DATA_TX
`ifdef ARP_STATS_EN
  ,
  output logic [15:0]           REQ_COUNT,
  output logic [15:0]           DROP_COUNT
`endif
);

  // ---------------- RX parse ----------------
  logic [5:0]  rx_cnt_q;       // saturates at ARP_LEN so padding is ignored
  logic [47:0] dst_q, sha_q;
  logic [31:0] spa_q;
  logic [23:0] tpa_q;          // first three TPA bytes; the fourth is live DATA_RX
  logic        hdr_ok_q;

  always_ff @(posedge CLK or posedge ARESET) begin
    if (ARESET) begin
      rx_cnt_q <= '0;
      dst_q    <= '0;
      sha_q    <= '0;
      spa_q    <= '0;
      tpa_q    <= '0;
      hdr_ok_q <= 1'b0;
    end else if (!DATA_VALID_RX) begin
      rx_cnt_q <= '0;
    end else begin
      if (rx_cnt_q != ARP_LEN) rx_cnt_q <= rx_cnt_q + 6'd1;
      if (rx_cnt_q < OFF_SRC) dst_q <= {dst_q[39:0], DATA_RX};
      if (rx_cnt_q == OFF_DST)
        hdr_ok_q <= 1'b1;
      else if (rx_cnt_q >= OFF_HDR && rx_cnt_q <= OFF_HDR_END)
        hdr_ok_q <= hdr_ok_q && (DATA_RX == req_hdr_byte(rx_cnt_q));
      if (rx_cnt_q >= OFF_SHA && rx_cnt_q < OFF_SPA) sha_q <= {sha_q[39:0], DATA_RX};
      if (rx_cnt_q >= OFF_SPA && rx_cnt_q < OFF_THA) spa_q <= {spa_q[23:0], DATA_RX};
      if (rx_cnt_q >= OFF_TPA && rx_cnt_q < OFF_LAST) tpa_q <= {tpa_q[15:0], DATA_RX};
    end
  end

  // Address table padded to MAX_IPV4 so a 3-bit index always lands in range.
  logic [31:0]         ip_tab [MAX_IPV4];
  logic [MAX_IPV4-1:0] ip_hit;
  logic [31:0]         tpa_full;
  logic [IDX_W-1:0]    match_idx_d;

  assign tpa_full = {tpa_q, DATA_RX};

  generate
    for (genvar gi = 0; gi < MAX_IPV4; gi++) begin : g_ip
      if (gi < NUM_IPV4) begin : g_used
        assign ip_tab[gi] = MY_IPV4[32*gi +: 32];
        assign ip_hit[gi] = IPV4_EN[gi] && (MY_IPV4[32*gi +: 32] == tpa_full);
      end else begin : g_unused
        assign ip_tab[gi] = '0;
        assign ip_hit[gi] = 1'b0;
      end
    end
  endgenerate

  // Lowest matching index wins: scan downward so the last hit written is the lowest.
  always_comb begin
    match_idx_d = '0;
    for (int k = MAX_IPV4 - 1; k >= 0; k--) begin
      if (ip_hit[k]) match_idx_d = IDX_W'(k);
    end
  end

  logic dst_ok, req_accept;
  assign dst_ok     = (dst_q == BCAST_MAC) || (dst_q == MY_MAC);
  assign req_accept = DATA_VALID_RX && (rx_cnt_q == OFF_LAST) &&
                      dst_ok && hdr_ok_q && (|ip_hit);

  // ---------------- reply queue ----------------
  arp_entry_t wr_entry, head;
  logic       fifo_empty, fifo_full, fifo_pop;

  assign wr_entry = '{sha: sha_q, spa: spa_q, idx: match_idx_d};

  arp_reply_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk_i   (CLK),
    .arst_i  (ARESET),
    .push_i  (req_accept),
    .wdata_i (wr_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // ---------------- TX ----------------
  tx_state_e                tx_state_q;
  logic [5:0]               tx_cnt_q;     // index of the byte currently on DATA_TX
  logic                     tx_valid_q;
  logic [7:0]               tx_data_q;
  logic [5:0]               byte_sel_d;
  logic [REPLY_BITS-1:0]    reply_vec;
  logic [8:0]               bit_lo;
  logic [7:0]               tx_byte_d;

  assign fifo_pop  = (tx_state_q == TX_SEND) && (tx_cnt_q == OFF_LAST);
  assign reply_vec = {head.sha, MY_MAC, RSP_HDR, MY_MAC, ip_tab[head.idx],
                      head.sha, head.spa};

  // Byte to load on the next edge: the following byte while sending, else byte 0.
  always_comb begin
    byte_sel_d = 6'd0;
    if (tx_state_q == TX_SEND && tx_cnt_q != OFF_LAST) byte_sel_d = tx_cnt_q + 6'd1;
  end

  assign bit_lo    = {6'(OFF_LAST - byte_sel_d), 3'b000};
  assign tx_byte_d = reply_vec[bit_lo +: 8];

  always_ff @(posedge CLK or posedge ARESET) begin
    if (ARESET) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (!fifo_empty) begin
            tx_state_q <= TX_PENDING;
            tx_valid_q <= 1'b1;
            tx_data_q  <= tx_byte_d;
          end
        end
        TX_PENDING: begin
          tx_data_q <= tx_byte_d;
          if (DATA_ACK_TX) begin
            tx_state_q <= TX_SEND;
            tx_cnt_q   <= '0;
          end
        end
        TX_SEND: begin
          if (tx_cnt_q == OFF_LAST) begin
            tx_state_q <= TX_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
          end else begin
            tx_cnt_q  <= tx_cnt_q + 6'd1;
            tx_data_q <= tx_byte_d;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign DATA_VALID_TX = tx_valid_q;
  assign DATA_TX       = tx_data_q;

`ifdef ARP_STATS_EN
  logic [15:0] req_cnt_q, drop_cnt_q;
  logic        drop_now;

  // A full queue still accepts when the head is popped on the same edge.
  assign drop_now = req_accept && fifo_full && !fifo_pop;

  always_ff @(posedge CLK or posedge ARESET) begin
    if (ARESET) begin
      req_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (req_accept && req_cnt_q != 16'hFFFF) req_cnt_q  <= req_cnt_q + 16'd1;
      if (drop_now && drop_cnt_q != 16'hFFFF)  drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign REQ_COUNT  = req_cnt_q;
  assign DROP_COUNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_arp_response_multi.sv
module tb_arp_response_multi;

  localparam int QD = 4;

  logic         CLK = 1'b0;
  logic         ARESET;
  logic [47:0]  MY_MAC;
  logic [127:0] MY_IPV4;
  logic [3:0]   IPV4_EN;
  logic         DATA_VALID_RX;
  logic [7:0]   DATA_RX;
  logic         DATA_ACK_TX;
  logic         DATA_VALID_TX;
  logic [7:0]   DATA_TX;
`ifdef ARP_STATS_EN
  logic [15:0]  REQ_COUNT, DROP_COUNT;
`endif

  arp_response_multi #(.NUM_IPV4(4), .QUEUE_DEPTH(QD)) dut (
    .CLK           (CLK),
    .ARESET        (ARESET),
    .MY_MAC        (MY_MAC),
    .MY_IPV4       (MY_IPV4),
    .IPV4_EN       (IPV4_EN),
    .DATA_VALID_RX (DATA_VALID_RX),
    .DATA_RX       (DATA_RX),
    .DATA_ACK_TX   (DATA_ACK_TX),
    .DATA_VALID_TX (DATA_VALID_TX),
    .DATA_TX       (DATA_TX)
`ifdef ARP_STATS_EN
    ,
    .REQ_COUNT     (REQ_COUNT),
    .DROP_COUNT    (DROP_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int           tests_run = 0;
  int           tests_failed = 0;
  int           exp_req = 0;
  int           exp_drop = 0;
  logic [335:0] sb [$];
  bit           seen_valid;

  always @(negedge CLK) if (DATA_VALID_TX === 1'b1) seen_valid = 1'b1;

  // Watchdog: stop with a FAIL line if anything ever runs away.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ip(input int k);
    return MY_IPV4[32*k +: 32];
  endfunction

  function automatic logic [335:0] mk_req(input logic [47:0] dst, input logic [47:0] sha,
                                          input logic [31:0] spa, input logic [31:0] tpa,
                                          input logic [15:0] op);
    return {dst, sha, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, op,
            sha, spa, 48'h0, tpa};
  endfunction

  function automatic logic [335:0] mk_rsp(input logic [47:0] sha, input logic [31:0] spa,
                                          input logic [31:0] myip);
    return {sha, MY_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
            MY_MAC, myip, sha, spa};
  endfunction

  // Drives nbytes bytes of f (zero padding beyond 42), then drops DATA_VALID_RX.
  task automatic send_frame(input logic [335:0] f, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge CLK);
      DATA_VALID_RX = 1'b1;
      DATA_RX = (i < 42) ? f[(41-i)*8 +: 8] : 8'h00;
    end
    @(negedge CLK);
    DATA_VALID_RX = 1'b0;
    DATA_RX = 8'h00;
  endtask

  // Model side of a pushed request: queue it or count it as dropped.
  task automatic model_req(input logic [335:0] rsp);
    exp_req++;
    if (sb.size() < QD) sb.push_back(rsp);
    else exp_drop++;
  endtask

  // Waits (bounded) for a pending reply, holds ACK back for pend cycles, then captures it.
  task automatic get_reply(input int pend, output logic [335:0] got, output int wait_cyc,
                           output logic [7:0] pend_byte, output int vbad,
                           output logic after_valid);
    got = '0; vbad = 0; after_valid = 1'b0; pend_byte = 8'h00;
    wait_cyc = 0;
    while (DATA_VALID_TX !== 1'b1 && wait_cyc < 300) begin
      @(negedge CLK);
      wait_cyc++;
    end
    if (DATA_VALID_TX !== 1'b1) begin
      wait_cyc = -1;
      return;
    end
    repeat (pend) @(negedge CLK);
    pend_byte = DATA_TX;
    DATA_ACK_TX = 1'b1;
    for (int i = 0; i < 42; i++) begin
      @(negedge CLK);
      if (i == 0) DATA_ACK_TX = 1'b0;
      got[(41-i)*8 +: 8] = DATA_TX;
      if (DATA_VALID_TX !== 1'b1) vbad++;
    end
    @(negedge CLK);
    after_valid = DATA_VALID_TX;
  endtask

  task automatic test_reset;
    ARESET = 1'b1; DATA_VALID_RX = 1'b0; DATA_RX = 8'h00; DATA_ACK_TX = 1'b0;
    MY_MAC  = 48'h02_11_22_33_44_55;
    MY_IPV4 = {32'h0A00_0006, 32'h0A00_0005, 32'hC0A8_0103, 32'hC0A8_0102};
    IPV4_EN = 4'b1111;
    repeat (3) @(negedge CLK);
    tests_run++;
    if (DATA_VALID_TX !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b required 0", DATA_VALID_TX);
    end
    tests_run++;
    if (DATA_TX !== 8'h00) begin
      tests_failed++; $display("FAIL reset_data: got %02h required 00", DATA_TX);
    end
`ifdef ARP_STATS_EN
    tests_run++;
    if (REQ_COUNT !== 16'd0 || DROP_COUNT !== 16'd0) begin
      tests_failed++; $display("FAIL reset_stats: got %0d/%0d required 0/0", REQ_COUNT, DROP_COUNT);
    end
`endif
    $display("[TB] reset checked");
  endtask

  // A frame already on the wire while reset releases counts from the first high cycle after.
  task automatic test_rx_after_reset;
    logic [335:0] f, got, exp;
    int wc, vb; logic [7:0] pb; logic av;
    f = mk_req(48'hFFFF_FFFF_FFFF, 48'h00AA_BB00_0001, 32'hC0A8_0150, ip(1), 16'h0001);
    ARESET = 1'b1;
    @(negedge CLK);
    DATA_VALID_RX = 1'b1; DATA_RX = 8'h5A;      // junk during reset
    @(negedge CLK);
    ARESET = 1'b0;
    for (int i = 0; i < 42; i++) begin
      if (i > 0) @(negedge CLK);
      DATA_RX = f[(41-i)*8 +: 8];
    end
    @(negedge CLK);
    DATA_VALID_RX = 1'b0; DATA_RX = 8'h00;
    model_req(mk_rsp(48'h00AA_BB00_0001, 32'hC0A8_0150, ip(1)));
    get_reply(1, got, wc, pb, vb, av);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    tests_run++;
    if (wc < 0 || got !== exp) begin
      tests_failed++; $display("FAIL rx_after_reset: got %h wait %0d required %h", got, wc, exp);
    end
    $display("[TB] reply after reset release: %h", got);
  endtask

  task automatic test_basic_reply;
    logic [335:0] got, exp;
    int wc, vb; logic [7:0] pb; logic av;
    send_frame(mk_req(48'hFFFF_FFFF_FFFF, 48'h0001_4200_5F68, 32'hC0A8_0101,
                      32'hC0A8_0102, 16'h0001), 42);
    model_req(mk_rsp(48'h0001_4200_5F68, 32'hC0A8_0101, 32'hC0A8_0102));
    get_reply(5, got, wc, pb, vb, av);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    tests_run++;
    if (wc < 0 || wc > 2) begin
      tests_failed++; $display("FAIL basic_latency: got %0d cycles required <=2", wc);
    end
    tests_run++;
    if (pb !== exp[335:328]) begin
      tests_failed++; $display("FAIL basic_pending_byte: got %02h required %02h", pb, exp[335:328]);
    end
    tests_run++;
    if (got !== exp) begin
      tests_failed++; $display("FAIL basic_reply: got %h required %h", got, exp);
    end
    tests_run++;
    if (vb !== 0 || av !== 1'b0) begin
      tests_failed++; $display("FAIL basic_valid: got gaps %0d after %b required 0/0", vb, av);
    end
    $display("[TB] basic reply: %h", got);
  endtask

  task automatic test_filter;
    logic [335:0] got, exp;
    int wc, vb; logic [7:0] pb; logic av;
    seen_valid = 1'b0;
    send_frame(mk_req(48'hFFFF_FFFF_FFFF, 48'h0001_4200_5F68, 32'hC0A8_0101,
                      32'hDEAD_BEEF, 16'h0001), 42);
    IPV4_EN = 4'b0011;
    send_frame(mk_req(48'hFFFF_FFFF_FFFF, 48'h0001_4200_5F68, 32'hC0A8_0101,
                      ip(2), 16'h0001), 42);
    IPV4_EN = 4'b1111;
    send_frame(mk_req(48'hFFFF_FFFF_FFFF, 48'h0001_4200_5F68, 32'hC0A8_0101,
                      ip(0), 16'h0002), 42);
    send_frame(mk_req(48'h0200_0000_0099, 48'h0001_4200_5F68, 32'hC0A8_0101,
                      ip(0), 16'h0001), 42);
    @(negedge CLK); DATA_ACK_TX = 1'b1;          // ACK while idle must be ignored
    @(negedge CLK); DATA_ACK_TX = 1'b0;
    repeat (6) @(negedge CLK);
    tests_run++;
    if (seen_valid !== 1'b0) begin
      tests_failed++; $display("FAIL filter_no_reply: got valid %b required 0", seen_valid);
    end
    $display("[TB] filtered frames produced no reply");
    IPV4_EN = 4'b1010;
    send_frame(mk_req(MY_MAC, 48'h0011_2233_4455, 32'h0A00_0001, ip(3), 16'h0001), 60);
    model_req(mk_rsp(48'h0011_2233_4455, 32'h0A00_0001, ip(3)));
    get_reply(0, got, wc, pb, vb, av);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    tests_run++;
    if (wc < 0 || got !== exp) begin
      tests_failed++; $display("FAIL filter_unicast: got %h required %h", got, exp);
    end
    IPV4_EN = 4'b1111;
    $display("[TB] unicast reply: %h", got);
  endtask

  task automatic test_abort;
    logic [335:0] got, exp;
    int wc, vb; logic [7:0] pb; logic av;
    send_frame(mk_req(48'hFFFF_FFFF_FFFF, 48'h0001_0000_0001, 32'hC0A8_0111,
                      ip(0), 16'h0001), 30);
    send_frame(mk_req(48'hFFFF_FFFF_FFFF, 48'h0001_0000_0002, 32'hC0A8_0112,
                      ip(0), 16'h0001), 42);
    model_req(mk_rsp(48'h0001_0000_0002, 32'hC0A8_0112, ip(0)));
    get_reply(2, got, wc, pb, vb, av);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    tests_run++;
    if (wc < 0 || got !== exp) begin
      tests_failed++; $display("FAIL abort_reply: got %h required %h", got, exp);
    end
    seen_valid = 1'b0;
    repeat (10) @(negedge CLK);
    tests_run++;
    if (av !== 1'b0 || seen_valid !== 1'b0) begin
      tests_failed++; $display("FAIL abort_single: got extra valid %b/%b required 0/0", av, seen_valid);
    end
    $display("[TB] aborted frame ignored, reply: %h", got);
  endtask

  task automatic test_queue_full;
    logic [335:0] got, exp;
    int wc, vb; logic [7:0] pb; logic av;
    for (int j = 0; j < 5; j++) begin
      send_frame(mk_req(48'hFFFF_FFFF_FFFF, 48'h0002_0000_0000 + 48'(j),
                        32'hC0A8_0200 + 32'(j), ip(j % 4), 16'h0001), 42);
      model_req(mk_rsp(48'h0002_0000_0000 + 48'(j), 32'hC0A8_0200 + 32'(j), ip(j % 4)));
    end
`ifdef ARP_STATS_EN
    tests_run++;
    if (DROP_COUNT !== 16'(exp_drop) || REQ_COUNT !== 16'(exp_req)) begin
      tests_failed++; $display("FAIL full_stats: got req %0d drop %0d required %0d %0d",
                               REQ_COUNT, DROP_COUNT, exp_req, exp_drop);
    end
`endif
    for (int j = 0; j < 4; j++) begin
      get_reply(1, got, wc, pb, vb, av);
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      tests_run++;
      if (wc < 0 || wc > 2 || got !== exp) begin
        tests_failed++; $display("FAIL full_reply%0d: got %h wait %0d required %h", j, got, wc, exp);
      end
      $display("[TB] queued reply %0d: %h", j, got);
    end
    seen_valid = 1'b0;
    repeat (10) @(negedge CLK);
    tests_run++;
    if (av !== 1'b0 || seen_valid !== 1'b0) begin
      tests_failed++; $display("FAIL full_fifth_dropped: got valid %b/%b required 0/0", av, seen_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [335:0] got, exp;
    int wc, vb, gw; logic [7:0] pb; logic av;
    for (int j = 0; j < 4; j++) begin
      send_frame(mk_req(48'hFFFF_FFFF_FFFF, 48'h0003_0000_0000 + 48'(j),
                        32'hC0A8_0300 + 32'(j), ip(j), 16'h0001), 42);
      model_req(mk_rsp(48'h0003_0000_0000 + 48'(j), 32'hC0A8_0300 + 32'(j), ip(j)));
    end
    gw = 0;
    while (DATA_VALID_TX !== 1'b1 && gw < 50) begin @(negedge CLK); gw++; end
    // Queue is full: the new request's last byte lands on the edge that pops the head.
    exp_req++;
    sb.push_back(mk_rsp(48'h0003_0000_00FF, 32'hC0A8_03FF, ip(0)));
    fork
      get_reply(0, got, wc, pb, vb, av);
      send_frame(mk_req(48'hFFFF_FFFF_FFFF, 48'h0003_0000_00FF, 32'hC0A8_03FF,
                        ip(0), 16'h0001), 42);
    join
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    tests_run++;
    if (wc < 0 || got !== exp) begin
      tests_failed++; $display("FAIL b2b_first: got %h required %h", got, exp);
    end
    $display("[TB] b2b reply 0: %h", got);
    for (int j = 1; j < 5; j++) begin
      get_reply(0, got, wc, pb, vb, av);
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      tests_run++;
      if (wc < 0 || wc > 2 || got !== exp) begin
        tests_failed++; $display("FAIL b2b_reply%0d: got %h wait %0d required %h wait<=2", j, got, wc, exp);
      end
      $display("[TB] b2b reply %0d: %h", j, got);
    end
`ifdef ARP_STATS_EN
    tests_run++;
    if (DROP_COUNT !== 16'(exp_drop) || REQ_COUNT !== 16'(exp_req)) begin
      tests_failed++; $display("FAIL b2b_stats: got req %0d drop %0d required %0d %0d",
                               REQ_COUNT, DROP_COUNT, exp_req, exp_drop);
    end
`endif
  endtask

  task automatic test_reset_mid_tx;
    logic [335:0] exp;
    int gw;
    send_frame(mk_req(48'hFFFF_FFFF_FFFF, 48'h0004_0000_0001, 32'hC0A8_0401,
                      ip(0), 16'h0001), 42);
    model_req(mk_rsp(48'h0004_0000_0001, 32'hC0A8_0401, ip(0)));
    send_frame(mk_req(48'hFFFF_FFFF_FFFF, 48'h0004_0000_0002, 32'hC0A8_0402,
                      ip(1), 16'h0001), 42);
    model_req(mk_rsp(48'h0004_0000_0002, 32'hC0A8_0402, ip(1)));
    exp = sb[0];
    gw = 0;
    while (DATA_VALID_TX !== 1'b1 && gw < 50) begin @(negedge CLK); gw++; end
    DATA_ACK_TX = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge CLK);
      if (i == 0) DATA_ACK_TX = 1'b0;
    end
    tests_run++;
    if (DATA_TX !== exp[(41-20)*8 +: 8]) begin
      tests_failed++; $display("FAIL rst_tx_byte20: got %02h required %02h", DATA_TX, exp[(41-20)*8 +: 8]);
    end
    ARESET = 1'b1;
    #1;
    tests_run++;
    if (DATA_VALID_TX !== 1'b0 || DATA_TX !== 8'h00) begin
      tests_failed++; $display("FAIL rst_tx_immediate: got %b/%02h required 0/00", DATA_VALID_TX, DATA_TX);
    end
    @(negedge CLK);
    ARESET = 1'b0;
    sb.delete(); exp_req = 0; exp_drop = 0;
    seen_valid = 1'b0;
    repeat (30) @(negedge CLK);
    tests_run++;
    if (seen_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rst_tx_queue_empty: got valid %b required 0", seen_valid);
    end
`ifdef ARP_STATS_EN
    tests_run++;
    if (REQ_COUNT !== 16'd0 || DROP_COUNT !== 16'd0) begin
      tests_failed++; $display("FAIL rst_tx_stats: got %0d/%0d required 0/0", REQ_COUNT, DROP_COUNT);
    end
`endif
    $display("[TB] reset during TX abandoned frame and queue");
  endtask

  initial begin
    test_reset();
    test_rx_after_reset();
    test_basic_reply();
    test_filter();
    test_abort();
    test_queue_full();
    test_back_to_back();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
